// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional macro BCD_LEADING_BLANK_EN enables the registered leading-zero blank mask.
`default_nettype none

module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  busy,
    output logic [DIGITS-1:0]     blank_o
);

    function automatic int min_digits(input int w);
        longint unsigned v;
        int              d;
        v = (64'd1 << w) - 64'd1;
        d = 0;
        while (v != 64'd0) begin
            d++;
            v = v / 64'd10;
        end
        return d;
    endfunction

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_width_check
            $error("bin_to_bcd_seq: WIDTH must be in 4..32");
        end
        if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
            $error("bin_to_bcd_seq: DIGITS too small to hold 2^WIDTH-1");
        end
    endgenerate

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [4*DIGITS-1:0]   scratch_q, scratch_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;

    logic [4*DIGITS-1:0]   adj_w;
    logic [4*DIGITS-1:0]   scratch_next_w;
    logic [WIDTH-1:0]      shift_next_w;
    logic [DIGITS-1:0]     blank_w;
    logic                  unused_msb_w;

    // Add-3 on digits 5..9, then shift {scratch, shift} left by one in the same cycle.
    always_comb begin
        adj_w = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj_w[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    assign scratch_next_w = {adj_w[4*DIGITS-2:0], shift_q[WIDTH-1]};
    assign shift_next_w   = {shift_q[WIDTH-2:0], 1'b0};
    assign unused_msb_w   = adj_w[4*DIGITS-1];

`ifdef BCD_LEADING_BLANK_EN
    always_comb begin : blank_calc
        logic nz_seen;
        nz_seen = 1'b0;
        blank_w = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (scratch_next_w[4*k +: 4] != 4'd0) begin
                nz_seen = 1'b1;
            end
            blank_w[k] = ~nz_seen;
        end
    end
`else
    assign blank_w = '0;
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d   = bin_i;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_next_w;
                shift_d   = shift_next_w;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d       = scratch_next_w;
                    blank_d     = blank_w;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            blank_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = out_valid_q;
    assign bcd_o     = bcd_q;
    assign blank_o   = blank_q;

endmodule

`default_nettype wire
